// File: rtl/cfu_buf_pkg.sv
// +-- cfu_buf_pkg -- rev 1.0 -----------------------------------------------+
// |   Shared defaults and wrap-aware pointer helpers for the CFU buffers.   |
`default_nettype none

package cfu_buf_pkg;

   localparam int CFU_BUF_WIDTH = 32;
   localparam int CFU_BUF_DEPTH = 256;
   localparam int unsigned PTR_MAX_W = 32;

   // Distance from b forward to a, modulo 2^ptr_w; callers zero-extend their pointers.
   function automatic logic [PTR_MAX_W-1:0] ptr_diff(
      input logic [PTR_MAX_W-1:0] a,
      input logic [PTR_MAX_W-1:0] b,
      input int unsigned          ptr_w
   );
      logic [PTR_MAX_W-1:0] mask;
      mask = (ptr_w >= PTR_MAX_W) ? '1 : ((PTR_MAX_W'(1) << ptr_w) - PTR_MAX_W'(1));
      return (a - b) & mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cfu_sdp_ram.sv
// +-- cfu_sdp_ram -- rev 1.0 -----------------------------------------------+
// |   Simple dual-port block RAM: one write port, one registered read port. |
`default_nettype none

module cfu_sdp_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/cfu_replay_buffer.sv
// +-- cfu_replay_buffer -- rev 1.0 -----------------------------------------+
// |   Block-RAM FIFO with prefetching read port and mark/rewind replay.     |
`default_nettype none

module cfu_replay_buffer
   import cfu_buf_pkg::*;
#(
   parameter int WIDTH    = CFU_BUF_WIDTH,
   parameter int DEPTH    = CFU_BUF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   write_en,
   input  logic [WIDTH-1:0]       write_data,
   output logic                   write_full,
   output logic                   write_almost_full,
   input  logic                   read_en,
   output logic [WIDTH-1:0]       read_data,
   output logic                   read_valid,
   input  logic                   mark,
   input  logic                   rewind,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] level
);

   localparam int          ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] FULL_LVL  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] mk_ptr_q, mk_ptr_d;
   logic             valid_q, valid_d;
   logic             seen_q, seen_d;

   logic             w_do_write;
   logic             w_do_read;
   logic [WIDTH-1:0] w_ram_rdata;
   logic [PTR_MAX_W-1:0] w_count_ext;
   logic [PTR_MAX_W-1:0] w_level_ext;
   logic             w_unused_hi;

   assign w_count_ext = ptr_diff(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(rd_ptr_q), PTR_W);
   assign w_level_ext = ptr_diff(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(mk_ptr_q), PTR_W);
   assign count       = w_count_ext[PTR_W-1:0];
   assign level       = w_level_ext[PTR_W-1:0];
   assign w_unused_hi = ^{w_count_ext[PTR_MAX_W-1:PTR_W], w_level_ext[PTR_MAX_W-1:PTR_W]};

   assign write_full        = (level == FULL_LVL);
   assign write_almost_full = (level >= AF_THRESH);

   assign w_do_write = write_en && !write_full && !clear;
   assign w_do_read  = read_en && valid_q && !rewind;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(w_do_write);
      rd_ptr_d = rd_ptr_q;
      mk_ptr_d = mk_ptr_q;
      if (rewind) begin
         rd_ptr_d = mk_ptr_q;
      end else begin
         if (w_do_read) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (mark) begin
            mk_ptr_d = rd_ptr_q + PTR_W'(w_do_read);
         end
      end
      // Compare against the registered write pointer: a word landing this edge
      // is not yet readable by the RAM, so it costs one extra bubble.
      valid_d = !rewind && (wr_ptr_q != rd_ptr_d);
      seen_d  = seen_q | valid_d;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         mk_ptr_d = '0;
         valid_d  = 1'b0;
         seen_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mk_ptr_q <= '0;
         valid_q  <= 1'b0;
         seen_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mk_ptr_q <= mk_ptr_d;
         valid_q  <= valid_d;
         seen_q   <= seen_d;
      end
   end

   // The RAM output register only loads when the result will be valid, so it
   // doubles as the holding register for read_data.
   cfu_sdp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_do_write),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (write_data),
      .re_i    (valid_d),
      .raddr_i (rd_ptr_d[ADDR_W-1:0]),
      .rdata_o (w_ram_rdata)
   );

   assign read_data  = seen_q ? w_ram_rdata : '0;
   assign read_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cfu_replay_buffer.sv
// +-- tb_cfu_replay_buffer -- rev 1.0 --------------------------------------+
// |   Directed self-checking bench for the mark/rewind replay FIFO.         |
`default_nettype none

module tb_cfu_replay_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        write_en;
   logic [31:0] write_data;
   logic        write_full;
   logic        write_almost_full;
   logic        read_en;
   logic [31:0] read_data;
   logic        read_valid;
   logic        mark;
   logic        rewind;
   logic [8:0]  count;
   logic [8:0]  level;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   cfu_replay_buffer #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (DEPTH - 4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .clear             (clear),
      .write_en          (write_en),
      .write_data        (write_data),
      .write_full        (write_full),
      .write_almost_full (write_almost_full),
      .read_en           (read_en),
      .read_data         (read_data),
      .read_valid        (read_valid),
      .mark              (mark),
      .rewind            (rewind),
      .count             (count),
      .level             (level)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      write_en   = 1'b1;
      write_data = d;
      step();
      write_en   = 1'b0;
   endtask

   task automatic pop(input logic m);
      read_en = 1'b1;
      mark    = m;
      step();
      read_en = 1'b0;
      mark    = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; write_en = 1'b0; write_data = '0;
      read_en = 1'b0; mark = 1'b0; rewind = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rst_state", 64'({read_valid, write_full, write_almost_full, count, level, read_data}), 64'(0));

      // Write to empty buffer: valid visible two edges later.
      push(32'hA5A5A5A5);
      chk("lat_t1_valid", 64'({read_valid, count}), 64'({1'b0, 9'd1}));
      step();
      chk("lat_t2_data", 64'({read_valid, read_data}), 64'({1'b1, 32'hA5A5A5A5}));
      pop(1'b1);
      chk("lat_popped", 64'({read_valid, count, level}), 64'(0));

      // Fill to full, overfill, drain with mark held.
      for (int i = 0; i < 256; i++) begin
         push(32'h100 + 32'(i));
         if (i == 250) chk("af_below", 64'({write_almost_full, level}), 64'({1'b0, 9'd251}));
         if (i == 251) chk("af_at", 64'({write_almost_full, level}), 64'({1'b1, 9'd252}));
      end
      chk("fill_full", 64'({write_full, write_almost_full, count, level}), 64'({2'b11, 9'd256, 9'd256}));
      push(32'hDEAD);
      chk("overfill_ignored", 64'({write_full, count}), 64'({1'b1, 9'd256}));
      for (int i = 0; i < 256; i++) begin
         chk("drain", 64'({read_valid, count, read_data}), 64'({1'b1, 9'(256 - i), 32'h100 + 32'(i)}));
         pop(1'b1);
      end
      chk("drain_empty", 64'({read_valid, write_full, count, level}), 64'(0));

      // Replay: two passes over the same 8 words.
      for (int i = 1; i <= 8; i++) push(32'(i));
      step();
      mark = 1'b1;
      step();
      mark = 1'b0;
      chk("rep_level", 64'({count, level}), 64'({9'd8, 9'd8}));
      for (int i = 1; i <= 8; i++) begin
         chk("rep_pass1", 64'({read_valid, level, read_data}), 64'({1'b1, 9'd8, 32'(i)}));
         pop(1'b0);
      end
      chk("rep_drained", 64'({read_valid, count, level}), 64'({1'b0, 9'd0, 9'd8}));
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      chk("rew_bubble", 64'({read_valid, count, level}), 64'({1'b0, 9'd8, 9'd8}));
      step();
      for (int i = 1; i <= 8; i++) begin
         chk("rep_pass2", 64'({read_valid, level, read_data}), 64'({1'b1, 9'd8, 32'(i)}));
         pop(1'b0);
      end
      mark = 1'b1;
      step();
      mark = 1'b0;
      chk("rep_release", 64'({count, level}), 64'(0));

      // Entries behind the mark are protected from overwrite.
      for (int i = 0; i < 256; i++) push(32'h200 + 32'(i));
      step();
      for (int i = 0; i < 4; i++) pop(1'b0);
      chk("rel_hold", 64'({write_full, count, level}), 64'({1'b1, 9'd252, 9'd256}));
      push(32'hBAD);
      chk("rel_blocked", 64'({write_full, count, level}), 64'({1'b1, 9'd252, 9'd256}));
      mark = 1'b1;
      step();
      mark = 1'b0;
      chk("rel_mark", 64'({write_full, count, level}), 64'({1'b0, 9'd252, 9'd252}));
      for (int i = 0; i < 4; i++) push(32'h300 + 32'(i));
      chk("rel_refull", 64'({write_full, count, level}), 64'({1'b1, 9'd256, 9'd256}));
      for (int i = 0; i < 256; i++) begin
         chk("rel_drain", 64'({read_valid, read_data}),
             64'({1'b1, (i < 252) ? 32'h204 + 32'(i) : 32'h300 + 32'(i - 252)}));
         pop(1'b1);
      end
      chk("rel_empty", 64'({count, level}), 64'(0));

      // Rewind wins over read_en and mark in the same cycle.
      push(32'h11); push(32'h22); push(32'h33);
      step();
      mark = 1'b1;
      step();
      mark = 1'b0;
      pop(1'b0);
      chk("sim_pre", 64'({read_valid, count, level, read_data}), 64'({1'b1, 9'd2, 9'd3, 32'h22}));
      rewind = 1'b1; read_en = 1'b1; mark = 1'b1;
      step();
      rewind = 1'b0; read_en = 1'b0; mark = 1'b0;
      chk("sim_rewind", 64'({read_valid, count, level}), 64'({1'b0, 9'd3, 9'd3}));
      step();
      chk("sim_head", 64'({read_valid, read_data}), 64'({1'b1, 32'h11}));
      for (int i = 0; i < 3; i++) pop(1'b1);
      push(32'h44);
      step();
      chk("wr_rd_pre", 64'({read_valid, count, read_data}), 64'({1'b1, 9'd1, 32'h44}));
      write_en = 1'b1; write_data = 32'h55; read_en = 1'b1; mark = 1'b1;
      step();
      write_en = 1'b0; read_en = 1'b0; mark = 1'b0;
      chk("wr_rd_bubble", 64'({read_valid, count, level}), 64'({1'b0, 9'd1, 9'd1}));
      step();
      chk("wr_rd_data", 64'({read_valid, read_data}), 64'({1'b1, 32'h55}));
      pop(1'b1);

      // Synchronous clear.
      push(32'h66); push(32'h67);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_state", 64'({read_valid, count, level, read_data}), 64'(0));
      push(32'h99);
      step();
      chk("clear_reuse", 64'({read_valid, count, read_data}), 64'({1'b1, 9'd1, 32'h99}));
      pop(1'b1);

      // Asynchronous reset between edges.
      for (int i = 0; i < 37; i++) push(32'h400 + 32'(i));
      step();
      chk("arst_pre", 64'({read_valid, count}), 64'({1'b1, 9'd37}));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_now", 64'({read_valid, count, level, read_data}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      push(32'h777);
      chk("arst_t1", 64'({read_valid, count}), 64'({1'b0, 9'd1}));
      step();
      chk("arst_t2", 64'({read_valid, count, read_data}), 64'({1'b1, 9'd1, 32'h777}));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
